// File: rtl/bus_source_sequencer.sv
// Bus-source sequencer: queues {src,dst} transfer requests and plays each one
// out as a one-cycle one-hot out-enable/load-enable pair, stalling for MDR.
module bus_source_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MDR_WAIT   = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_src,
    input  logic [4:0]  req_dst,
    output logic [23:0] src_out,
    output logic [23:0] dst_in,
    output logic        busy,
    output logic        err_bad_src
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = (MDR_WAIT > 1) ? $clog2(MDR_WAIT) : 1;
    localparam logic [4:0] MDR_CODE = 5'd21;
    localparam logic [4:0] NUM_CODES = 5'd24;

    typedef enum logic [1:0] {IDLE, WAIT, DRIVE} stateT;

    stateT          state, stateNext;
    logic [9:0]     fifoMem [FIFO_DEPTH];
    logic [PW-1:0]  wrPtr, rdPtr;
    logic [CW-1:0]  count, countNext;
    logic [WW-1:0]  waitCnt, waitNext;
    logic [4:0]     curSrc, curDst, curSrcNext, curDstNext;
    logic [4:0]     headSrc, headDst;
    logic           push, pop, errNext;

    assign push    = req_valid && req_ready;
    assign headSrc = fifoMem[rdPtr][9:5];
    assign headDst = fifoMem[rdPtr][4:0];

    always_comb begin
        stateNext  = state;
        waitNext   = waitCnt;
        curSrcNext = curSrc;
        curDstNext = curDst;
        errNext    = err_bad_src;
        pop        = 1'b0;
        unique case (state)
            IDLE, DRIVE: begin
                stateNext = IDLE;
                if (count != '0) begin
                    pop = 1'b1;
                    if (headSrc >= NUM_CODES) begin
                        // illegal source: entry is discarded, nothing driven
                        errNext = 1'b1;
                    end else begin
                        curSrcNext = headSrc;
                        curDstNext = headDst;
                        if (headSrc == MDR_CODE && MDR_WAIT > 0) begin
                            stateNext = WAIT;
                            waitNext  = WW'(MDR_WAIT - 1);
                        end else begin
                            stateNext = DRIVE;
                        end
                    end
                end
            end
            WAIT: begin
                if (waitCnt == '0) stateNext = DRIVE;
                else waitNext = waitCnt - 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        countNext = count;
        unique case ({push, pop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) fifoMem[wrPtr] <= {req_src, req_dst};
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            waitCnt     <= '0;
            curSrc      <= '0;
            curDst      <= '0;
            err_bad_src <= 1'b0;
            req_ready   <= 1'b1;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitNext;
            curSrc      <= curSrcNext;
            curDst      <= curDstNext;
            err_bad_src <= errNext;
            count       <= countNext;
            req_ready   <= (countNext != CW'(FIFO_DEPTH));
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
        end
    end

    // enables appear the cycle after the FSM sits in DRIVE
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            src_out <= '0;
            dst_in  <= '0;
            busy    <= 1'b0;
        end else begin
            src_out <= '0;
            dst_in  <= '0;
            if (state == DRIVE) begin
                src_out <= 24'(1) << curSrc;
                if (curDst < NUM_CODES) dst_in <= 24'(1) << curDst;
            end
            busy <= (countNext != '0) || (stateNext != IDLE) || (state == DRIVE);
        end
    end

endmodule

// File: tb/tb_bus_source_sequencer.sv
// Scoreboard bench for bus_source_sequencer: accepted legal requests queue an
// expected enable pair, compared whenever the DUT drives a transfer.
module tb_bus_source_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [4:0]  reqSrc = '0;
    logic [4:0]  reqDst = '0;
    logic [23:0] srcOut, dstIn;
    logic        busy, errBadSrc;

    int nTests = 0;
    int nFail  = 0;
    int cycle  = 0;
    logic [47:0] expQ [$];
    int driveLog [$];

    bus_source_sequencer #(.FIFO_DEPTH(4), .MDR_WAIT(2)) dut (
        .clock(clock), .clear(clear),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_src(reqSrc), .req_dst(reqDst),
        .src_out(srcOut), .dst_in(dstIn),
        .busy(busy), .err_bad_src(errBadSrc)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [47:0] got,
                         input logic [47:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] expOf(input logic [4:0] s,
                                          input logic [4:0] d);
        logic [23:0] so, di;
        so = 24'(1) << s;
        di = (d < 5'd24) ? (24'(1) << d) : 24'd0;
        return {so, di};
    endfunction

    always @(posedge clock) begin
        cycle++;
        if (!clear && reqValid && reqReady && reqSrc < 5'd24)
            expQ.push_back(expOf(reqSrc, reqDst));
    end

    always @(posedge clear) expQ.delete();

    always @(negedge clock) begin
        if (!clear) begin
            check("onehotSrc", 48'($onehot0(srcOut)), 48'd1);
            check("onehotDst", 48'($onehot0(dstIn)), 48'd1);
            if (dstIn != 0) check("dstNeedsSrc", 48'(srcOut != 0), 48'd1);
            if (srcOut != 0) begin
                driveLog.push_back(cycle);
                if (expQ.size() == 0) check("unexpected", {srcOut, dstIn}, 48'd0);
                else check("xfer", {srcOut, dstIn}, expQ.pop_front());
            end
        end
    end

    // Inputs change at posedge+1; the task returns at posedge+1 after acceptance.
    task automatic push(input logic [4:0] s, input logic [4:0] d);
        int guard;
        guard = 0;
        reqValid = 1'b1;
        reqSrc = s;
        reqDst = d;
        while (!reqReady && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 50) check("pushTimeout", 48'(reqReady), 48'd1);
        @(posedge clock); #1;
        reqValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 200) check("drainTimeout", 48'(busy), 48'd0);
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 clear = 1'b1;
        #1;
        check("rstSrc",   48'(srcOut), 48'd0);
        check("rstReady", 48'(reqReady), 48'd1);
        check("rstBusy",  48'(busy), 48'd0);
        check("rstErr",   48'(errBadSrc), 48'd0);
        @(posedge clock); #1 clear = 1'b0;
        idle(2);

        // PC -> MDR, two-cycle latency
        push(5'd20, 5'd21);
        @(negedge clock); check("t2lat0", {srcOut, dstIn}, 48'd0);
        @(negedge clock); check("t2lat1", {srcOut, dstIn}, 48'd0);
        @(negedge clock); check("t2drive", {srcOut, dstIn}, {24'h100000, 24'h200000});
        @(negedge clock); check("t2after", {srcOut, dstIn}, 48'd0);
        check("t2busy", 48'(busy), 48'd0);
        idle(1);

        // MDR source adds two wait cycles
        push(5'd21, 5'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); check("t3wait", {srcOut, dstIn}, 48'd0);
        end
        @(negedge clock); check("t3drive", {srcOut, dstIn}, {24'h200000, 24'h000008});
        idle(1);
        waitIdle();

        // two MDR transfers stall the drain so the queue fills
        driveLog.delete();
        push(5'd21, 5'd0);
        push(5'd21, 5'd1);
        push(5'd2, 5'd3);
        push(5'd4, 5'd5);
        push(5'd6, 5'd7);
        push(5'd8, 5'd9);
        check("t4full", 48'(reqReady), 48'd0);
        push(5'd10, 5'd11);
        waitIdle();
        n = driveLog.size();
        check("t4count", 48'(n), 48'd7);
        if (n >= 5) begin
            for (int i = 0; i < 4; i++)
                check("t4consec", 48'(driveLog[n-4+i] - driveLog[n-5+i]), 48'd1);
        end

        // illegal source dropped, sticky error
        check("t5errPre", 48'(errBadSrc), 48'd0);
        push(5'd27, 5'd2);
        push(5'd1, 5'd30);
        waitIdle();
        check("t5err", 48'(errBadSrc), 48'd1);
        check("t5drained", 48'(expQ.size()), 48'd0);

        // random traffic against the reference queue
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0)
                push(5'($urandom_range(0, 25)), 5'($urandom_range(0, 31)));
            else
                idle(1);
        end
        waitIdle();
        check("t6drained", 48'(expQ.size()), 48'd0);
        check("t6errSticky", 48'(errBadSrc), 48'd1);

        // reset while an MDR transfer is in WAIT
        push(5'd21, 5'd3);
        @(posedge clock); #2 clear = 1'b1;
        #1;
        check("t1src",   {srcOut, dstIn}, 48'd0);
        check("t1busy",  48'(busy), 48'd0);
        check("t1ready", 48'(reqReady), 48'd1);
        check("t1err",   48'(errBadSrc), 48'd0);
        #1 clear = 1'b0;
        idle(8);
        check("t1idle", 48'(busy), 48'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
